// File: rtl/axi4_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi4_lite_pkg
// Shared definitions for the AXI4-Lite two-master arbiter:
//   - write and read FSM state encodings
//   - master index constants (M1 = bit 0, M2 = bit 1 of every grant vector)
//   - default timeout length and counter width
// -----------------------------------------------------------------------------
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    localparam int M1 = 0;
    localparam int M2 = 1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 7;

endpackage

// File: rtl/axi4_lite_rr_arb.sv
// -----------------------------------------------------------------------------
// axi4_lite_rr_arb
// Two-way round-robin pick. Purely combinational; the caller registers the
// result together with its FSM state.
// Ports:
//   req      in  2  request vector, bit 0 = master 1, bit 1 = master 2
//   last_m2  in  1  last-served pointer: 1 = master 2 was served last
//   grant    out 2  one-hot winner, 0 when nobody requests
// -----------------------------------------------------------------------------
module axi4_lite_rr_arb
    import axi4_lite_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_m2,
    output logic [1:0] grant
);

    // Winner select: a lone requester always wins, a tie goes to the master
    // that was not served last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[M1] = 1'b1;
            2'b10:   grant[M2] = 1'b1;
            2'b11: begin
                if (last_m2) begin
                    grant[M1] = 1'b1;
                end else begin
                    grant[M2] = 1'b1;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi4_lite_arbiter
// Transaction-level arbiter sharing the AXI4-Lite slave-side path between
// master 1 and master 2. Write (AW/W/B) and read (AR/R) are arbitrated by two
// independent FSMs; each grant is held for one complete transaction and the
// round-robin pointer advances only when a transaction finishes.
//
// Optional feature (macro AXI4_LITE_ARB_TIMEOUT_EN):
//   defined     - per-channel busy counter forces the FSM back to idle after
//                 TIMEOUT_CYCLES cycles without completion and pulses the
//                 matching timeout_err bit for one cycle.
//   not defined - no counters, grants are held until completion, timeout_err
//                 is tied to 0.
//
// Ports:
//   aclk        in  1  clock, rising edge
//   areset      in  1  synchronous active-high reset
//   m_awvalid   in  2  AWVALID per master (bit0 = M1, bit1 = M2)
//   m_arvalid   in  2  ARVALID per master
//   aw_hs/w_hs/b_hs/ar_hs/r_hs  in 1  muxed channel handshakes
//   wr_grant    out 2  one-hot write owner, 0 = none
//   rd_grant    out 2  one-hot read owner, 0 = none
//   timeout_err out 2  one-cycle pulse, bit0 write, bit1 read
// -----------------------------------------------------------------------------
module axi4_lite_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
)
(
    input  logic       aclk,
    input  logic       areset,
    input  logic [1:0] m_awvalid,
    input  logic [1:0] m_arvalid,
    input  logic       aw_hs,
    input  logic       w_hs,
    input  logic       b_hs,
    input  logic       ar_hs,
    input  logic       r_hs,
    output logic [1:0] wr_grant,
    output logic [1:0] rd_grant,
    output logic [1:0] timeout_err
);

    wr_state_t  wr_state_r;
    rd_state_t  rd_state_r;
    logic [1:0] wr_grant_r;
    logic [1:0] rd_grant_r;
    logic       wr_ptr_r;      // 1 = master 2 served last
    logic       rd_ptr_r;
    logic       aw_done_r;
    logic       w_done_r;
    logic       aw_seen_s;
    logic       w_seen_s;
    logic [1:0] wr_pick_s;
    logic [1:0] rd_pick_s;
    logic       wr_abort_s;    // forced release this cycle
    logic       rd_abort_s;

    axi4_lite_rr_arb u_wr_arb (
        .req     (m_awvalid),
        .last_m2 (wr_ptr_r),
        .grant   (wr_pick_s)
    );

    axi4_lite_rr_arb u_rd_arb (
        .req     (m_arvalid),
        .last_m2 (rd_ptr_r),
        .grant   (rd_pick_s)
    );

    // Address/data phase progress including handshakes landing this cycle,
    // so AW and W in the same cycle complete the phase at once.
    always_comb begin
        aw_seen_s = aw_done_r | aw_hs;
        w_seen_s  = w_done_r  | w_hs;
    end

`ifdef AXI4_LITE_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic             wr_to_r;
    logic             rd_to_r;
    logic             wr_expire_s;
    logic             rd_expire_s;

    // Expiry is suppressed when the closing handshake arrives on the same edge.
    always_comb begin
        wr_expire_s = (wr_state_r != W_IDLE) && (wr_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        rd_expire_s = (rd_state_r != R_IDLE) && (rd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        wr_abort_s  = wr_expire_s & ~((wr_state_r == W_RESP) & b_hs);
        rd_abort_s  = rd_expire_s & ~((rd_state_r == R_DATA) & r_hs);
    end

    // Busy counters: held at 0 while idle, count every cycle a grant is open.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_cnt_r <= {CNT_W{1'b0}};
            rd_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wr_cnt_r <= (wr_state_r == W_IDLE) ? {CNT_W{1'b0}} : wr_cnt_r + CNT_W'(1);
            rd_cnt_r <= (rd_state_r == R_IDLE) ? {CNT_W{1'b0}} : rd_cnt_r + CNT_W'(1);
        end
    end

    // Error pulses: high for the single cycle following a forced release.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_to_r <= 1'b0;
            rd_to_r <= 1'b0;
        end else begin
            wr_to_r <= wr_abort_s;
            rd_to_r <= rd_abort_s;
        end
    end

    assign timeout_err = {rd_to_r, wr_to_r};
`else
    assign wr_abort_s  = 1'b0;
    assign rd_abort_s  = 1'b0;
    assign timeout_err = 2'b00;

    // Timeout parameters only matter with the feature built in; this empty
    // guard keeps the configuration relation visible in every build.
    if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_too_small
    end
`endif

    // Write FSM: grant on request, collect AW and W in any order, release on B.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_r <= W_IDLE;
            wr_grant_r <= 2'b00;
            wr_ptr_r   <= 1'(M2);
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
        end else begin
            case (wr_state_r)
                W_IDLE: begin
                    if (m_awvalid != 2'b00) begin
                        wr_grant_r <= wr_pick_s;
                        wr_state_r <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (wr_abort_s) begin
                        wr_state_r <= W_IDLE;
                        wr_grant_r <= 2'b00;
                        wr_ptr_r   <= wr_grant_r[M2];
                        aw_done_r  <= 1'b0;
                        w_done_r   <= 1'b0;
                    end else if (aw_seen_s && w_seen_s) begin
                        wr_state_r <= W_RESP;
                        aw_done_r  <= 1'b0;
                        w_done_r   <= 1'b0;
                    end else begin
                        aw_done_r  <= aw_seen_s;
                        w_done_r   <= w_seen_s;
                    end
                end
                W_RESP: begin
                    if (b_hs || wr_abort_s) begin
                        wr_state_r <= W_IDLE;
                        wr_grant_r <= 2'b00;
                        wr_ptr_r   <= wr_grant_r[M2];
                    end
                end
                default: begin
                    wr_state_r <= W_IDLE;
                    wr_grant_r <= 2'b00;
                    aw_done_r  <= 1'b0;
                    w_done_r   <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: grant on request, wait for AR, release on R.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_r <= R_IDLE;
            rd_grant_r <= 2'b00;
            rd_ptr_r   <= 1'(M2);
        end else begin
            case (rd_state_r)
                R_IDLE: begin
                    if (m_arvalid != 2'b00) begin
                        rd_grant_r <= rd_pick_s;
                        rd_state_r <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (rd_abort_s) begin
                        rd_state_r <= R_IDLE;
                        rd_grant_r <= 2'b00;
                        rd_ptr_r   <= rd_grant_r[M2];
                    end else if (ar_hs) begin
                        rd_state_r <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs || rd_abort_s) begin
                        rd_state_r <= R_IDLE;
                        rd_grant_r <= 2'b00;
                        rd_ptr_r   <= rd_grant_r[M2];
                    end
                end
                default: begin
                    rd_state_r <= R_IDLE;
                    rd_grant_r <= 2'b00;
                end
            endcase
        end
    end

    assign wr_grant = wr_grant_r;
    assign rd_grant = rd_grant_r;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_arbiter
// Cycle-stepped bench: each step drives inputs, pushes the outputs expected
// after the next rising edge into a scoreboard queue, then pops and compares
// them #1 after that edge. Timeout scenarios depend on AXI4_LITE_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_axi4_lite_arbiter;

    localparam logic [4:0] HS_NONE = 5'b00000;
    localparam logic [4:0] HS_AW   = 5'b10000;
    localparam logic [4:0] HS_W    = 5'b01000;
    localparam logic [4:0] HS_B    = 5'b00100;
    localparam logic [4:0] HS_AR   = 5'b00010;
    localparam logic [4:0] HS_R    = 5'b00001;

    logic       aclk;
    logic       areset;
    logic [1:0] m_awvalid;
    logic [1:0] m_arvalid;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;
    logic       ar_hs;
    logic       r_hs;
    logic [1:0] wr_grant;
    logic [1:0] rd_grant;
    logic [1:0] timeout_err;

    int total_cnt;
    int bad_cnt;

    logic [5:0] exp_q[$];   // {timeout_err, rd_grant, wr_grant}
    string      tag_q[$];

    axi4_lite_arbiter #(
        .TIMEOUT_CYCLES (8),
        .CNT_W          (4)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .m_awvalid   (m_awvalid),
        .m_arvalid   (m_arvalid),
        .aw_hs       (aw_hs),
        .w_hs        (w_hs),
        .b_hs        (b_hs),
        .ar_hs       (ar_hs),
        .r_hs        (r_hs),
        .wr_grant    (wr_grant),
        .rd_grant    (rd_grant),
        .timeout_err (timeout_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock step: drive, enqueue expectation, clock, dequeue and compare.
    task automatic cyc(input logic [1:0] awv, input logic [1:0] arv, input logic [4:0] hs,
                       input logic [1:0] e_wr, input logic [1:0] e_rd, input logic [1:0] e_to,
                       input string tag);
        logic [5:0] e;
        string      t;
        m_awvalid = awv;
        m_arvalid = arv;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs} = hs;
        exp_q.push_back({e_to, e_rd, e_wr});
        tag_q.push_back(tag);
        @(posedge aclk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_val({t, "_wr"}, {6'd0, wr_grant},    {6'd0, e[1:0]});
        check_val({t, "_rd"}, {6'd0, rd_grant},    {6'd0, e[3:2]});
        check_val({t, "_to"}, {6'd0, timeout_err}, {6'd0, e[5:4]});
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        areset    = 1'b1;
        // Reset state
        cyc(2'b00, 2'b00, HS_NONE, 2'b00, 2'b00, 2'b00, "rst0");
        cyc(2'b11, 2'b11, HS_NONE, 2'b00, 2'b00, 2'b00, "rst1");
        areset = 1'b0;

        // Master 1 alone, AW and W a cycle apart, then B
        cyc(2'b01, 2'b00, HS_NONE, 2'b01, 2'b00, 2'b00, "t1_grant");
        cyc(2'b01, 2'b00, HS_AW,   2'b01, 2'b00, 2'b00, "t1_aw");
        cyc(2'b01, 2'b00, HS_W,    2'b01, 2'b00, 2'b00, "t1_w");
        cyc(2'b00, 2'b00, HS_B,    2'b00, 2'b00, 2'b00, "t1_b");
        cyc(2'b00, 2'b00, HS_NONE, 2'b00, 2'b00, 2'b00, "t1_idle");

        // Ties from reset: M1, then M2 two cycles after B, then M1 again
        areset = 1'b1;
        cyc(2'b00, 2'b00, HS_NONE, 2'b00, 2'b00, 2'b00, "t2_rst");
        areset = 1'b0;
        cyc(2'b11, 2'b00, HS_NONE,      2'b01, 2'b00, 2'b00, "t2_tie1");
        cyc(2'b11, 2'b00, HS_AW | HS_W, 2'b01, 2'b00, 2'b00, "t2_aw_w_same");
        cyc(2'b11, 2'b00, HS_B,         2'b00, 2'b00, 2'b00, "t2_b1");
        cyc(2'b11, 2'b00, HS_NONE,      2'b10, 2'b00, 2'b00, "t2_tie2");
        cyc(2'b11, 2'b00, HS_AW,        2'b10, 2'b00, 2'b00, "t2_aw2");
        cyc(2'b11, 2'b00, HS_W,         2'b10, 2'b00, 2'b00, "t2_w2");
        cyc(2'b11, 2'b00, HS_B,         2'b00, 2'b00, 2'b00, "t2_b2");
        cyc(2'b11, 2'b00, HS_NONE,      2'b01, 2'b00, 2'b00, "t2_tie3");

        // Spurious B during address phase, valid dropped while granted
        cyc(2'b11, 2'b00, HS_B,         2'b01, 2'b00, 2'b00, "t3_spur_b");
        cyc(2'b01, 2'b00, HS_AW | HS_B, 2'b01, 2'b00, 2'b00, "t3_aw_b");
        cyc(2'b00, 2'b00, HS_W,         2'b01, 2'b00, 2'b00, "t3_w");
        cyc(2'b00, 2'b00, HS_B,         2'b00, 2'b00, 2'b00, "t3_b");

        // Concurrent write by M1 and read by M2
        cyc(2'b01, 2'b10, HS_NONE,       2'b01, 2'b10, 2'b00, "t4_grant");
        cyc(2'b00, 2'b00, HS_AW | HS_AR, 2'b01, 2'b10, 2'b00, "t4_aw_ar");
        cyc(2'b00, 2'b00, HS_W | HS_R,   2'b01, 2'b00, 2'b00, "t4_w_r");
        cyc(2'b00, 2'b00, HS_B,          2'b00, 2'b00, 2'b00, "t4_b");

        // Read by M1 so that, without reset, M2 would win the next read tie
        cyc(2'b00, 2'b01, HS_NONE, 2'b00, 2'b01, 2'b00, "t5_grant");
        cyc(2'b00, 2'b00, HS_AR,   2'b00, 2'b01, 2'b00, "t5_ar");
        cyc(2'b00, 2'b00, HS_R,    2'b00, 2'b00, 2'b00, "t5_r");

        // Reset during R_DATA restores pointers to M2
        cyc(2'b11, 2'b11, HS_NONE, 2'b10, 2'b10, 2'b00, "t6_grant");
        cyc(2'b11, 2'b11, HS_AR,   2'b10, 2'b10, 2'b00, "t6_ar");
        areset = 1'b1;
        cyc(2'b11, 2'b11, HS_NONE, 2'b00, 2'b00, 2'b00, "t6_rst");
        areset = 1'b0;
        cyc(2'b11, 2'b11, HS_NONE,              2'b01, 2'b01, 2'b00, "t6_tie");
        cyc(2'b00, 2'b00, HS_AW | HS_W | HS_AR, 2'b01, 2'b01, 2'b00, "t6_addr");
        cyc(2'b00, 2'b00, HS_B | HS_R,          2'b00, 2'b00, 2'b00, "t6_done");

        // Timeout behaviour from a fresh reset
        areset = 1'b1;
        cyc(2'b00, 2'b00, HS_NONE, 2'b00, 2'b00, 2'b00, "t7_rst");
        areset = 1'b0;
`ifdef AXI4_LITE_ARB_TIMEOUT_EN
        cyc(2'b11, 2'b00, HS_NONE,      2'b01, 2'b00, 2'b00, "to_grant");
        cyc(2'b11, 2'b00, HS_AW | HS_W, 2'b01, 2'b00, 2'b00, "to_aw_w");
        for (int i = 2; i < 8; i++) begin
            cyc(2'b11, 2'b00, HS_NONE, 2'b01, 2'b00, 2'b00, "to_wait");
        end
        cyc(2'b11, 2'b00, HS_NONE,      2'b00, 2'b00, 2'b01, "to_expire");
        cyc(2'b11, 2'b00, HS_NONE,      2'b10, 2'b00, 2'b00, "to_next_m2");
        cyc(2'b00, 2'b00, HS_AW | HS_W, 2'b10, 2'b00, 2'b00, "to_aw_w2");
        for (int i = 0; i < 6; i++) begin
            cyc(2'b00, 2'b00, HS_NONE, 2'b10, 2'b00, 2'b00, "to_wait2");
        end
        cyc(2'b00, 2'b00, HS_B,    2'b00, 2'b00, 2'b00, "to_b_at_expiry");
        cyc(2'b00, 2'b00, HS_NONE, 2'b00, 2'b00, 2'b00, "to_idle");
`else
        cyc(2'b01, 2'b00, HS_NONE,      2'b01, 2'b00, 2'b00, "hold_grant");
        cyc(2'b01, 2'b00, HS_AW | HS_W, 2'b01, 2'b00, 2'b00, "hold_aw_w");
        for (int i = 0; i < 100; i++) begin
            cyc(2'b00, 2'b00, HS_NONE, 2'b01, 2'b00, 2'b00, "hold_wait");
        end
        cyc(2'b00, 2'b00, HS_B,    2'b00, 2'b00, 2'b00, "hold_b");
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
